// File: rtl/pipe_ctl_pkg.sv
// Shared state encodings and hazard helper for the pipeline controller.
// Imported by pipe_ctl; keeps encodings in one place for debug tooling.
package pipe_ctl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    PCTL_RUN      = 2'd0,
    PCTL_MC_WAIT  = 2'd1,
    PCTL_REDIRECT = 2'd2
  } pctl_state_e;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             rs1_used,
    input logic             rs2_used,
    input logic             is_load,
    input logic [REG_W-1:0] rd
  );
    return is_load && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_ctl.sv
// Central stall/flush sequencer for the 5-stage core: decodes per-stage enables/bubbles.
// Zero-latency combinational outputs; data-memory wait freezes everything and holds state.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int MC_LATENCY = 32,
  parameter int FETCH_LAT  = 1,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mc_start,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             mc_busy
);

  localparam logic [CNT_W-1:0] MC_INIT    = CNT_W'(MC_LATENCY - 1);
  localparam logic [CNT_W-1:0] FETCH_INIT = CNT_W'(FETCH_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pctl_state_e      state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             memstall;
  logic             advancing;
  logic             lu_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PCTL_RUN;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    pc_en        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    en_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    mc_busy      = 1'b0;
    memstall     = dmem_req && !dmem_ready;
    // MC_WAIT with cnt==0 is the release cycle and behaves like RUN, minus a new MC start.
    advancing    = (state != PCTL_MC_WAIT) || (cnt == '0);
    lu_act       = (state != PCTL_REDIRECT) &&
                   load_use_hit(id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_is_load, ex_rd);

    if (!rst_n) begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      en_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (memstall) begin
      pc_en     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
      mc_busy   = !advancing;
    end else if (!advancing) begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      flush_ex_mem = 1'b1;
      mc_busy      = 1'b1;
      nxt_cnt      = cnt - CNT_ONE;
    end else if (ex_mc_start && (state != PCTL_MC_WAIT)) begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      flush_ex_mem = 1'b1;
      mc_busy      = 1'b1;
      nxt_cnt      = MC_INIT;
      nxt_state    = PCTL_MC_WAIT;
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      nxt_cnt     = FETCH_INIT;
      nxt_state   = PCTL_REDIRECT;
    end else begin
      nxt_state = PCTL_RUN;
      if (state == PCTL_REDIRECT) begin
        flush_if_id = 1'b1;
        if (cnt != '0) begin
          nxt_cnt   = cnt - CNT_ONE;
          nxt_state = PCTL_REDIRECT;
        end
      end else if (lu_act) begin
        pc_en       = 1'b0;
        en_if_id    = 1'b0;
        flush_id_ex = 1'b1;
      end
      // Fetch wait: a stalled IF/ID must keep its instruction rather than take a bubble.
      if (!imem_ready) begin
        pc_en = 1'b0;
        if (!lu_act) flush_if_id = 1'b1;
      end
    end
  end

endmodule
